reg_file_wb: RTL and testbench

//  RV32I integer register file with its write-back path. It is the write-side

---
 rtl/rv_pkg.sv | 11 +
 rtl/reg_file_wb_if.sv | 27 ++
 rtl/reg_wr_decoder.sv | 20 ++
 rtl/reg_file_wb.sv | 75 +++++++
 tb/tb_reg_file_wb.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I register-file constants: data width, register count, address width.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  // Architectural zero register; it reads 0 and ignores writes.
  localparam logic [AW-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/reg_file_wb_if.sv
// Write-back and operand-read bus of the register file.
// Write side: we/rd/wd are sampled on posedge clk (no handshake; we qualifies rd/wd).
// Read side: rs1/rs2 are addresses; rd1/rd2 are combinational data, valid in the same cycle.
interface reg_file_wb_if;
  import rv_pkg::*;

  logic            we;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // Core side: issues writes and read addresses, consumes read data.
  modport master (
    output we, rd, wd, rs1, rs2,
    input  rd1, rd2
  );

  // Register file side.
  modport slave (
    input  we, rd, wd, rs1, rs2,
    output rd1, rd2
  );

endinterface

// File: rtl/reg_wr_decoder.sv
// Write-address demux: decodes addr to a one-hot enable vector, gated by en.
// Bit 0 (x0) is never enabled so x0 stays hard-wired to zero.
module reg_wr_decoder
  import rv_pkg::*;
(
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [NREGS-1:0] onehot
);

  // One-hot decode with the x0 lane forced off.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_wb.sv
// RV32I integer register file with write-back demux, two combinational read
// ports with optional write-through forwarding, a debug read port and a
// committed-write counter.
module reg_file_wb
  import rv_pkg::*;
#(
  parameter int BYPASS = 1
)
(
  input  logic                clk,
  input  logic                rst,
  reg_file_wb_if.slave        bus,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [15:0]         wr_cnt
);

  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] wr_en;
  logic             wr_any;

  // Reset dominates: a write in the reset cycle never reaches any register.
  reg_wr_decoder u_dec (
    .en     (bus.we & ~rst),
    .addr   (bus.rd),
    .onehot (wr_en)
  );

  assign wr_any = |wr_en;

  // Register array: clear on reset, otherwise load wd into the enabled register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= bus.wd;
        end
      end
    end
  end

  // Committed-write counter; x0 writes and reset-cycle writes are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (wr_any) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Read ports: x0 reads zero; a same-cycle write to the read address is
  // forwarded when bypass is enabled (wr_en already excludes x0 and reset).
  always_comb begin
    bus.rd1 = (bus.rs1 == REG_X0) ? '0 : regs[bus.rs1];
    bus.rd2 = (bus.rs2 == REG_X0) ? '0 : regs[bus.rs2];
    if (BYPASS_EN && wr_en[bus.rs1]) begin
      bus.rd1 = bus.wd;
    end
    if (BYPASS_EN && wr_en[bus.rs2]) begin
      bus.rd2 = bus.wd;
    end
  end

  // Debug port always shows stored state, never the in-flight write.
  always_comb begin
    dbg_data = (dbg_addr == REG_X0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: a BYPASS=1 and a BYPASS=0 instance driven with the
// same stimulus; expectations come from an array-based register model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data_b, dbg_data_n;
  logic [15:0] wr_cnt_b, wr_cnt_n;

  reg_file_wb_if bif ();
  reg_file_wb_if nif ();

  reg_file_wb #(.BYPASS(1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data_b),
    .wr_cnt   (wr_cnt_b)
  );

  reg_file_wb #(.BYPASS(0)) dut_n (
    .clk      (clk),
    .rst      (rst),
    .bus      (nif),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data_n),
    .wr_cnt   (wr_cnt_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] ref_regs [32];
  int unsigned ref_cnt;

  // Inputs currently applied (committed at the next posedge).
  logic        cur_rst, cur_we;
  logic [4:0]  cur_rd, cur_rs1, cur_rs2, cur_dbg;
  logic [31:0] cur_wd;

  typedef struct {
    int          id;
    logic [31:0] exp;
  } chk_t;

  chk_t exp_q [$];
  int checks = 0;
  int passes = 0;

  string chk_name [8] = '{"rd1_byp", "rd2_byp", "dbg_byp", "cnt_byp",
                          "rd1_nob", "rd2_nob", "dbg_nob", "cnt_nob"};

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (byp && cur_we && !cur_rst && cur_rd != 5'd0 && cur_rd == a) return cur_wd;
    if (a == 5'd0) return 32'd0;
    return ref_regs[a];
  endfunction

  task automatic commit();
    if (cur_rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_cnt = 0;
    end else if (cur_we && cur_rd != 5'd0) begin
      ref_regs[cur_rd] = cur_wd;
      ref_cnt = (ref_cnt + 1) % 65536;
    end
  endtask

  task automatic push_expect();
    chk_t c;
    c.id = 0; c.exp = exp_read(cur_rs1, 1'b1); exp_q.push_back(c);
    c.id = 1; c.exp = exp_read(cur_rs2, 1'b1); exp_q.push_back(c);
    c.id = 2; c.exp = exp_read(cur_dbg, 1'b0); exp_q.push_back(c);
    c.id = 3; c.exp = 32'(ref_cnt);            exp_q.push_back(c);
    c.id = 4; c.exp = exp_read(cur_rs1, 1'b0); exp_q.push_back(c);
    c.id = 5; c.exp = exp_read(cur_rs2, 1'b0); exp_q.push_back(c);
    c.id = 6; c.exp = exp_read(cur_dbg, 1'b0); exp_q.push_back(c);
    c.id = 7; c.exp = 32'(ref_cnt);            exp_q.push_back(c);
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic r, input logic w, input logic [4:0] a_rd,
                       input logic [31:0] a_wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ad);
    cur_rst = r; cur_we = w; cur_rd = a_rd; cur_wd = a_wd;
    cur_rs1 = a1; cur_rs2 = a2; cur_dbg = ad;
    rst = r; dbg_addr = ad;
    bif.we = w; bif.rd = a_rd; bif.wd = a_wd; bif.rs1 = a1; bif.rs2 = a2;
    nif.we = w; nif.rd = a_rd; nif.wd = a_wd; nif.rs1 = a1; nif.rs2 = a2;
  endtask

  // One cycle: the edge commits the previous inputs, then new inputs go on.
  task automatic step(input logic r, input logic w, input logic [4:0] a_rd,
                      input logic [31:0] a_wd, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] ad, input bit chk);
    @(posedge clk);
    commit();
    #1;
    apply(r, w, a_rd, a_wd, a1, a2, ad);
    if (chk) push_expect();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = exp_q.pop_front();
      case (c.id)
        0: act = bif.rd1;
        1: act = bif.rd2;
        2: act = dbg_data_b;
        3: act = {16'd0, wr_cnt_b};
        4: act = nif.rd1;
        5: act = nif.rd2;
        6: act = dbg_data_n;
        default: act = {16'd0, wr_cnt_n};
      endcase
      checks++;
      if (act !== c.exp)
        $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", chk_name[c.id], $time, act, c.exp);
      else
        passes++;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned pre_cnt;

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_cnt = 0;
    // Reset cycle with a write that must be dropped.
    apply(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5, 1'b1);

    // Plain write then read back.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5, 1'b1);

    // Write to x0 is dropped and not counted.
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 5'd0, 1'b1);

    // Forwarding vs old value on the same register.
    step(1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 32'hBBBBBBBB, 5'd7, 5'd7, 5'd7, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 1'b1);

    // Randomized traffic, occasional reset with a concurrent write.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a_rd, a1, a2;
      a_rd = 5'($urandom_range(0, 31));
      a1   = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
      a2   = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a_rd,
           $urandom, a1, a2, 5'($urandom_range(0, 31)), 1'b1);
    end

    // Fill x1..x31 with their index, then sweep the debug port.
    for (int i = 1; i < 32; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 5'(i), 1'b1);
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'(31 - i), 5'(i), 5'(i), 1'b1);

    // 65536 counted writes bring wr_cnt back to its starting value.
    pre_cnt = ref_cnt;
    for (int i = 0; i < 65536; i++)
      step(1'b0, 1'b1, 5'd1, $urandom, 5'd1, 5'd2, 5'd1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 5'd1, 1'b1);
    checks++;
    if (ref_cnt != pre_cnt)
      $display("FAIL wrap_model: got %0d expected %0d", ref_cnt, pre_cnt);
    else
      passes++;

    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
